// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, FSM state type and flat-bus segment extract for snake_collision.
package snake_pkg;
    localparam int COORD_W   = 9;
    localparam int MAX_LEN   = 32;
    localparam int SEG_WIDTH = 20;
    localparam int IDX_W     = $clog2(MAX_LEN);
    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int FLAT_W    = MAX_LEN * COORD_W;

    typedef enum logic [2:0] {
        IDLE,
        WALL,
        SCAN,
        FOOD,
        REPORT
    } state_t;

    function automatic logic [COORD_W-1:0] seg_extract(input logic [FLAT_W-1:0] flat,
                                                       input logic [IDX_W-1:0]  idx);
        return flat[int'(idx)*COORD_W +: COORD_W];
    endfunction
endpackage

// File: rtl/snake_collision_if.sv
// rtl/snake_collision_if.sv - position-block/checker handshake; SNAKE_SCORE_EN adds the score output.
interface snake_collision_if;
    import snake_pkg::*;

    logic               step;
    logic [FLAT_W-1:0]  snake_x_flat;
    logic [FLAT_W-1:0]  snake_y_flat;
    logic [COORD_W-1:0] food_x;
    logic [COORD_W-1:0] food_y;
    logic               busy;
    logic               done;
    logic               grow;
    logic               dead;
    logic [LEN_W-1:0]   len;
`ifdef SNAKE_SCORE_EN
    logic [7:0]         score;
`endif

    modport master (
        output step, snake_x_flat, snake_y_flat, food_x, food_y,
`ifdef SNAKE_SCORE_EN
        input  score,
`endif
        input  busy, done, grow, dead, len
    );

    modport slave (
        input  step, snake_x_flat, snake_y_flat, food_x, food_y,
`ifdef SNAKE_SCORE_EN
        output score,
`endif
        output busy, done, grow, dead, len
    );
endinterface

// File: rtl/snake_seg_mux.sv
// rtl/snake_seg_mux.sv - combinational MAX_LEN:1 selector for one segment's {x,y}.
module snake_seg_mux
    import snake_pkg::*;
(
    input  logic [FLAT_W-1:0]  x_flat_i,
    input  logic [FLAT_W-1:0]  y_flat_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o
);
    assign x_o = seg_extract(x_flat_i, idx_i);
    assign y_o = seg_extract(y_flat_i, idx_i);
endmodule

// File: rtl/snake_collision.sv
// rtl/snake_collision.sv - per-move wall/body/food check producing dead, grow and length.
// Optional score counter enabled by SNAKE_SCORE_EN.
module snake_collision
    import snake_pkg::*;
#(
    parameter int X_MAX = 480,
    parameter int Y_MAX = 460
) (
    input  logic               clk,
    input  logic               rst,
    snake_collision_if.slave   bus
);
    localparam logic [COORD_W-1:0] X_LIM   = X_MAX[COORD_W-1:0];
    localparam logic [COORD_W-1:0] Y_LIM   = Y_MAX[COORD_W-1:0];
    localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_TOP = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hit_q, hit_d;
    logic               eat_q, eat_d;
    logic               dead_q;
    logic [LEN_W-1:0]   len_q;
    logic [COORD_W-1:0] head_x_q, head_y_q, food_x_q, food_y_q;
    logic [COORD_W-1:0] seg_x, seg_y;
    logic               start;

    snake_seg_mux u_seg_mux (
        .x_flat_i (bus.snake_x_flat),
        .y_flat_i (bus.snake_y_flat),
        .idx_i    (idx_q),
        .x_o      (seg_x),
        .y_o      (seg_y)
    );

    assign start = (state_q == IDLE) && bus.step && !dead_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        eat_d   = eat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WALL;
                    hit_d   = 1'b0;
                    eat_d   = 1'b0;
                end
            end
            WALL: begin
                // Left/top underflow wraps to a large unsigned value and lands here too.
                if (head_x_q > X_LIM || head_y_q > Y_LIM) begin
                    hit_d   = 1'b1;
                    state_d = REPORT;
                end else if (len_q == LEN_ONE) begin
                    state_d = FOOD;
                end else begin
                    state_d = SCAN;
                    idx_d   = IDX_W'(1);
                end
            end
            SCAN: begin
                if (seg_x == head_x_q && seg_y == head_y_q) begin
                    hit_d   = 1'b1;
                    state_d = REPORT;
                end else if ({1'b0, idx_q} == len_q - LEN_ONE) begin
                    state_d = FOOD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FOOD: begin
                eat_d   = (head_x_q == food_x_q) && (head_y_q == food_y_q);
                state_d = REPORT;
            end
            REPORT: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == REPORT);
    assign bus.grow = bus.done && !hit_q && eat_q;
    assign bus.dead = dead_q || (bus.done && hit_q);
    assign bus.len  = len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            eat_q    <= 1'b0;
            dead_q   <= 1'b0;
            len_q    <= LEN_ONE;
            head_x_q <= '0;
            head_y_q <= '0;
            food_x_q <= '0;
            food_y_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            eat_q   <= eat_d;
            if (start) begin
                head_x_q <= seg_extract(bus.snake_x_flat, IDX_W'(0));
                head_y_q <= seg_extract(bus.snake_y_flat, IDX_W'(0));
                food_x_q <= bus.food_x;
                food_y_q <= bus.food_y;
            end
            if (bus.done && hit_q) begin
                dead_q <= 1'b1;
            end
            if (bus.grow && len_q != LEN_TOP) begin
                len_q <= len_q + LEN_ONE;
            end
        end
    end

`ifdef SNAKE_SCORE_EN
    logic [7:0] score_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else if (bus.grow && score_q != 8'hFF) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign bus.score = score_q;
`endif
endmodule

// File: doc/snake_collision.md
Name: snake_collision

Overview:
- Consumer of the segment coordinates produced by the snake position block.
- After every move, scans head vs. walls, body and food, then returns the `dead` and `grow` controls that the position block consumes.
- Tracks current snake length internally.
- Sits between the position block and the game/VGA top; timing is driven by the game tick (`step`).

Parameters:
- COORD_W, 9, coordinate width in bits.
- MAX_LEN, 32, segment capacity; must match the position block.
- X_MAX, 480, largest legal head x; must be < 512 - SEG_WIDTH so left-edge underflow reads as out of range.
- Y_MAX, 460, largest legal head y; same constraint as X_MAX.
- SEG_WIDTH, 20, segment pitch; used only for the constraint check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- step  in  1  one-cycle pulse: the snake has just moved; start a check.
- snake_x_flat  in  MAX_LEN*COORD_W  segment x coordinates; segment i at bits [i*9 +: 9]; segment 0 is the head.
- snake_y_flat  in  MAX_LEN*COORD_W  segment y coordinates; same packing as x.
- food_x  in  COORD_W  food x.
- food_y  in  COORD_W  food y.
- busy  out  1  high while a check is in progress.
- done  out  1  one-cycle pulse: result is valid this cycle.
- grow  out  1  one-cycle pulse in the done cycle when food was eaten.
- dead  out  1  sticky collision flag.
- len  out  6  current snake length, 1..MAX_LEN.

Behaviour:
- Reset: busy=0, done=0, grow=0, dead=0, len=1, state=IDLE, scan index=0.
- Reset taken mid-check aborts the scan; no done pulse is issued.
- States: IDLE, WALL, SCAN, FOOD, REPORT.
- IDLE:
  - step=1 and dead=0: latch head (segment 0) and food coordinates; go to WALL.
  - step while dead=1: ignored.
- WALL (cycle T+1, where T = step cycle):
  - head_x > X_MAX or head_y > Y_MAX (unsigned compare): set hit, go to REPORT.
  - Otherwise: if len=1 go to FOOD, else go to SCAN with idx=1.
- SCAN: one segment per cycle; segment idx is compared in cycle T+1+idx.
  - Exact x and y match with head: set hit, go to REPORT.
  - idx=len-1 with no match: go to FOOD.
  - Segments at idx >= len are never compared.
- FOOD (cycle T+len+1): record eat = (head == latched food); go to REPORT.
- REPORT (one cycle): done=1.
  - hit: dead becomes 1 and stays 1 until rst; grow=0.
  - No hit and eat: grow=1; len increments at the next edge, saturating at MAX_LEN.
  - eat at MAX_LEN: grow still pulses; len holds.
  - Next state: IDLE.
- Latency from step to done:
  - Wall hit: T+2.
  - Self hit at index i: T+2+i.
  - Clean move: T+len+2.
- busy is high from T+1 through the REPORT cycle inclusive.
- step while busy=1: ignored (no queueing); the check in flight is unaffected.
- Input coordinates must be stable from step until done; only head and food are latched.
- grow and dead are never both high in the same cycle.

Optional Feature:
- Macro: SNAKE_SCORE_EN.
- Defined:
  - Adds output `score` (8 bits, reset 0).
  - score increments by 1 on each grow pulse, saturating at 255.
  - score clears on rst only.
- Undefined: no score port and no score logic; all other behaviour identical.

Decomposition:
- Package snake_pkg:
  - COORD_W, MAX_LEN, SEG_WIDTH constants.
  - State enum (IDLE, WALL, SCAN, FOOD, REPORT).
  - Helper function for flat-bus segment extract.
- Sub-module snake_seg_mux: combinational MAX_LEN:1 selector returning the {x,y} of segment idx from the flat buses. The FSM instantiates it once, for the scan index.

Test Plan:
- Reset, then step with head (300,300), food (100,100), len=1 -> done at T+3, grow=0, dead=0, len stays 1.
- Head (300,300), food (300,300) -> done at T+3 with grow=1; len=2 next cycle; with SNAKE_SCORE_EN, score=1.
- Head x=500 (left underflow wrap) -> done at T+2, dead=1; a later step leaves busy=0.
- len=5, segment 3 equal to head (240,300) -> done at T+5, dead=1, grow=0; segment 4 never compared.
- len=32, head equal to food -> grow pulses, len stays 32. Second step issued at T+2 while busy -> ignored; exactly one done pulse.
- rst asserted in SCAN at len=10 -> next cycle busy=0, done=0, len=1, dead=0; no done pulse follows.
